// File: rtl/fifo_chain.sv
// Cascade of N_STAGES power-of-two valid/ready FIFO stages with total occupancy count,
// registered almost_full and synchronous flush. Define FIFO_CHAIN_PEAK_EN to add the peak port.
module fifo_chain #(
    parameter int D_WIDTH  = 6,
    parameter int A_WIDTH  = 2,
    parameter int N_STAGES = 2,
    parameter int AF_LEVEL = 6,
    localparam int DEPTH    = 2 ** A_WIDTH,
    localparam int CAPACITY = N_STAGES * DEPTH,
    localparam int CNT_W    = $clog2(CAPACITY + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [D_WIDTH-1:0] up_data,
    input  logic               up_valid,
    output logic               up_ready,
    output logic [D_WIDTH-1:0] down_data,
    output logic               down_valid,
    input  logic               down_ready,
`ifdef FIFO_CHAIN_PEAK_EN
    output logic [CNT_W-1:0]   peak,
`endif
    output logic [CNT_W-1:0]   count,
    output logic               almost_full
);

    // link k is the boundary feeding stage k; link N_STAGES is the chain output
    logic [D_WIDTH-1:0] link_data [N_STAGES+1];
    logic [N_STAGES:0]  link_valid;
    logic [N_STAGES:0]  link_ready;

    assign link_data[0]          = up_data;
    assign link_valid[0]         = up_valid;
    assign link_ready[N_STAGES]  = down_ready;

    for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_stage
        logic [D_WIDTH-1:0] mem [DEPTH];
        logic [A_WIDTH:0]   wr_ptr_q, wr_ptr_d;
        logic [A_WIDTH:0]   rd_ptr_q, rd_ptr_d;
        logic               full;
        logic               empty;
        logic               push;
        logic               pop;

        // full/empty depend on flops only, so ready/valid never combine across stages
        assign full  = (wr_ptr_q[A_WIDTH-1:0] == rd_ptr_q[A_WIDTH-1:0]) &&
                       (wr_ptr_q[A_WIDTH] != rd_ptr_q[A_WIDTH]);
        assign empty = (wr_ptr_q == rd_ptr_q);

        assign link_ready[gi]    = !full;
        assign link_valid[gi+1]  = !empty;
        assign link_data[gi+1]   = mem[rd_ptr_q[A_WIDTH-1:0]];

        always_comb begin
            push     = link_valid[gi] && !full;
            pop      = !empty && link_ready[gi+1];
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            if (flush) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
            end else begin
                if (push) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
            end
        end

        // storage is not reset; a write during flush is harmless since pointers clear
        always_ff @(posedge clk) begin
            if (push) begin
                mem[wr_ptr_q[A_WIDTH-1:0]] <= link_data[gi];
            end
        end
    end

    logic             up_fire;
    logic             down_fire;
    logic [CNT_W-1:0] count_q, count_d;
    logic             almost_full_q, almost_full_d;

    assign up_ready   = link_ready[0] && !flush;
    assign down_valid = link_valid[N_STAGES] && !flush;
    assign down_data  = link_data[N_STAGES];

    always_comb begin
        up_fire   = up_valid && up_ready;
        down_fire = down_valid && down_ready;
        count_d   = count_q;
        if (flush) begin
            count_d = '0;
        end else if (up_fire && !down_fire) begin
            count_d = count_q + 1'b1;
        end else if (!up_fire && down_fire) begin
            count_d = count_q - 1'b1;
        end
        almost_full_d = (count_d >= CNT_W'(AF_LEVEL));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q       <= '0;
            almost_full_q <= 1'b0;
        end else begin
            count_q       <= count_d;
            almost_full_q <= almost_full_d;
        end
    end

    assign count       = count_q;
    assign almost_full = almost_full_q;

`ifdef FIFO_CHAIN_PEAK_EN
    logic [CNT_W-1:0] peak_q, peak_d;

    always_comb begin
        peak_d = peak_q;
        if (flush) begin
            peak_d = '0;
        end else if (count_d > peak_q) begin
            peak_d = count_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak = peak_q;
`endif

endmodule

// File: tb/tb_fifo_chain.sv
// Self-checking bench for fifo_chain: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations. Honours FIFO_CHAIN_PEAK_EN.
module tb_fifo_chain;
    localparam int DW  = 6;
    localparam int AW  = 2;
    localparam int NS  = 2;
    localparam int AF  = 6;
    localparam int CAP = NS * (2 ** AW);
    localparam int CW  = $clog2(CAP + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] up_data = '0;
    logic          up_valid = 1'b0;
    logic          up_ready;
    logic [DW-1:0] down_data;
    logic          down_valid;
    logic          down_ready = 1'b0;
    logic [CW-1:0] count;
    logic          almost_full;
`ifdef FIFO_CHAIN_PEAK_EN
    logic [CW-1:0] peak;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fifo_chain #(.D_WIDTH(DW), .A_WIDTH(AW), .N_STAGES(NS), .AF_LEVEL(AF)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .up_data     (up_data),
        .up_valid    (up_valid),
        .up_ready    (up_ready),
        .down_data   (down_data),
        .down_valid  (down_valid),
        .down_ready  (down_ready),
`ifdef FIFO_CHAIN_PEAK_EN
        .peak        (peak),
`endif
        .count       (count),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the chain is an ordered queue bounded by CAP words
    logic [DW-1:0] mq [$];
    int            mpeak = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst) begin
            mq.delete();
            mpeak = 0;
            prev_stall = 0;
        end else begin
            chk("m_count", count, mq.size());
            chk("m_almost_full", almost_full, mq.size() >= AF);
            if (mq.size() == 0) chk("m_empty_no_valid", down_valid, 1'b0);
            if (mq.size() == CAP) chk("m_full_no_ready", up_ready, 1'b0);
            if (flush) begin
                chk("m_flush_up_ready", up_ready, 1'b0);
                chk("m_flush_down_valid", down_valid, 1'b0);
            end
            if (down_valid && mq.size() > 0) chk("m_data", down_data, mq[0]);
            if (prev_stall && !flush) begin
                chk("m_stall_valid", down_valid, 1'b1);
                chk("m_stall_data", down_data, prev_data);
            end
`ifdef FIFO_CHAIN_PEAK_EN
            chk("m_peak", peak, mpeak);
`endif
            if (flush) begin
                mq.delete();
                mpeak = 0;
                prev_stall = 0;
            end else begin
                prev_stall = down_valid && !down_ready;
                prev_data  = down_data;
                if (down_valid && down_ready && mq.size() > 0) void'(mq.pop_front());
                if (up_valid && up_ready) mq.push_back(up_data);
                if (mq.size() > mpeak) mpeak = mq.size();
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n, input logic [DW-1:0] base);
        down_ready = 1'b0;
        up_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            up_data = base + DW'(i);
            @(negedge clk);
            chk("fill_up_ready", up_ready, 1'b1);
            step();
        end
        up_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [DW-1:0] v, input int budget);
        bit seen;
        seen = 0;
        down_ready = 1'b1;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (down_valid) begin
                seen = 1;
                chk(name, down_data, v);
            end
            step();
        end
        chk({name, "_seen"}, seen, 1'b1);
    endtask

    task automatic push_one_and_expect(input string name, input logic [DW-1:0] v);
        up_valid = 1'b1;
        up_data = v;
        down_ready = 1'b1;
        @(negedge clk);
        chk({name, "_accept"}, up_ready, 1'b1);
        step();
        up_valid = 1'b0;
        expect_out(name, v, 10);
    endtask

    initial begin
        $display("T1 reset");
        step();
        step();
        @(negedge clk);
        chk("t1_in_reset_count", count, 0);
        chk("t1_in_reset_up_ready", up_ready, 1'b1);
        chk("t1_in_reset_down_valid", down_valid, 1'b0);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("t1_up_ready", up_ready, 1'b1);
        chk("t1_down_valid", down_valid, 1'b0);
        chk("t1_count", count, 0);
        chk("t1_almost_full", almost_full, 1'b0);
        step();

        $display("T2 fill to capacity, hold 0x09, then drain");
        down_ready = 1'b0;
        up_valid = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            up_data = DW'(k);
            @(negedge clk);
            chk("t2_count", count, k - 1);
            chk("t2_almost_full", almost_full, (k - 1) >= 6);
            if (k <= 8) chk("t2_up_ready", up_ready, 1'b1);
            else chk("t2_full_up_ready", up_ready, 1'b0);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_held_up_ready", up_ready, 1'b0);
            chk("t2_held_count", count, 8);
            step();
        end
        down_ready = 1'b1;
        begin
            int got;
            bit acc;
            got = 0;
            for (int c = 0; c < 40 && got < 9; c++) begin
                @(negedge clk);
                acc = up_valid && up_ready;
                if (down_valid) begin
                    chk("t2_order", down_data, got + 1);
                    got++;
                end
                step();
                if (acc) up_valid = 1'b0;
            end
            chk("t2_words_out", got, 9);
        end
        @(negedge clk);
        chk("t2_empty_count", count, 0);
        step();

        $display("T3 single word latency");
        up_valid = 1'b1;
        up_data = 6'h2A;
        @(negedge clk);
        chk("t3_up_ready", up_ready, 1'b1);
        step();
        up_valid = 1'b0;
        for (int k = 0; k < NS - 1; k++) begin
            @(negedge clk);
            chk("t3_not_yet_valid", down_valid, 1'b0);
            chk("t3_count_in_flight", count, 1);
            step();
        end
        @(negedge clk);
        chk("t3_valid", down_valid, 1'b1);
        chk("t3_data", down_data, 6'h2A);
        chk("t3_count_one", count, 1);
        step();
        @(negedge clk);
        chk("t3_count_zero", count, 0);
        chk("t3_drained", down_valid, 1'b0);
        step();

        $display("T4 streaming 20 words");
        begin
            int sent;
            int got;
            bit acc;
            sent = 0;
            got = 0;
            up_valid = 1'b1;
            up_data = '0;
            down_ready = 1'b1;
            for (int c = 0; c < 60 && got < 20; c++) begin
                @(negedge clk);
                if (up_valid) chk("t4_up_ready", up_ready, 1'b1);
                if (got > 0) chk("t4_no_bubble", down_valid, 1'b1);
                if (down_valid) begin
                    chk("t4_data", down_data, got);
                    got++;
                end
                if (down_valid && up_valid) chk("t4_count_steady", count, 2);
                acc = up_valid && up_ready;
                step();
                if (acc) begin
                    sent++;
                    if (sent < 20) up_data = DW'(sent);
                    else up_valid = 1'b0;
                end
            end
            chk("t4_words_out", got, 20);
        end

        $display("T5 random traffic");
        begin
            int sent;
            bit acc;
            sent = 0;
            up_valid = 1'b0;
            for (int c = 0; c < 3000 && sent < 100; c++) begin
                if (!up_valid) begin
                    up_valid = 1'($urandom_range(0, 1));
                    up_data = DW'($urandom);
                end
                down_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                acc = up_valid && up_ready;
                step();
                if (acc) begin
                    sent++;
                    up_valid = 1'b0;
                end
            end
            chk("t5_words_sent", sent, 100);
            up_valid = 1'b0;
            down_ready = 1'b1;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (count == 0) break;
                step();
            end
            chk("t5_drained", count, 0);
            step();
        end

        $display("T6a flush at count 5");
        fill(5, 6'h30);
        up_valid = 1'b1;
        up_data = 6'h3F;
        down_ready = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("t6_pre_count", count, 5);
        chk("t6_flush_up_ready", up_ready, 1'b0);
        chk("t6_flush_down_valid", down_valid, 1'b0);
        step();
        flush = 1'b0;
        up_valid = 1'b0;
        @(negedge clk);
        chk("t6_count", count, 0);
        chk("t6_down_valid", down_valid, 1'b0);
        chk("t6_up_ready", up_ready, 1'b1);
        chk("t6_almost_full", almost_full, 1'b0);
`ifdef FIFO_CHAIN_PEAK_EN
        chk("t6_peak", peak, 0);
`endif
        step();
        push_one_and_expect("t6_after_flush", 6'h15);

        $display("T6b async reset at count 5");
        fill(5, 6'h20);
        up_valid = 1'b1;
        up_data = 6'h3E;
        down_ready = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("t6r_async_count", count, 0);
        chk("t6r_async_down_valid", down_valid, 1'b0);
        chk("t6r_async_up_ready", up_ready, 1'b1);
        @(negedge clk);
        step();
        up_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("t6r_count", count, 0);
        chk("t6r_down_valid", down_valid, 1'b0);
        chk("t6r_up_ready", up_ready, 1'b1);
`ifdef FIFO_CHAIN_PEAK_EN
        chk("t6r_peak", peak, 0);
`endif
        step();
        push_one_and_expect("t6r_after_reset", 6'h15);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/fifo_chain.md
Name: fifo_chain

Overview:
- Parametrised cascade of N_STAGES valid/ready FIFO stages. Each stage has power-of-two depth.
- Generalises the fixed two-FIFO buffer to any stage count.
- Adds total-occupancy count, almost-full flag and synchronous flush.
- Sits between an upstream producer and a downstream consumer as an elastic buffer. Also used as a retiming chain across long routes.

Parameters:
- D_WIDTH, 6, data width in bits.
- A_WIDTH, 2, per-stage address width; stage depth = 2**A_WIDTH. Must be >= 1.
- N_STAGES, 2, number of cascaded stages. Must be >= 1.
- AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL. Legal range 1..N_STAGES*2**A_WIDTH.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all stages.
- up_data  input  D_WIDTH  upstream data.
- up_valid  input  1  upstream data valid.
- up_ready  output  1  chain can accept a word.
- down_data  output  D_WIDTH  downstream data.
- down_valid  output  1  downstream data valid.
- down_ready  input  1  consumer accepts the word.
- count  output  CNT_W  total words held, where CNT_W = $clog2(N_STAGES*2**A_WIDTH+1).
- almost_full  output  1  registered, high when count >= AF_LEVEL.

Behaviour:
- Reset: rst is asynchronous and active-low. While rst=0, all stage pointers, count and almost_full are 0. This gives up_ready=1 and down_valid=0. Memory contents are not reset.
- Stage structure:
  - Storage array of 2**A_WIDTH words.
  - Write and read pointers of A_WIDTH+1 bits, wrapping naturally.
  - Empty when pointers are equal. Full when the low A_WIDTH bits are equal and the MSB differs.
  - Stage out-data = mem[rd_ptr[A_WIDTH-1:0]], read combinationally from flops.
  - Stage ready = !full. Stage valid = !empty.
- Handshake:
  - A transfer occurs on any edge where valid && ready.
  - Stage k downstream connects to stage k+1 upstream.
  - The chain's up side is stage 0; the down side is stage N_STAGES-1.
- Latency: a word accepted on an empty chain at edge t appears with down_valid=1 after edge t+N_STAGES-1. There is no combinational path from up to down.
- Throughput: 1 word/cycle sustained when down_ready=1.
- Full stage: ready is 0 even if a pop occurs in the same cycle (no pass-through). Push and pop in the same cycle on a non-full, non-empty stage both occur.
- Stability: while down_valid=1 and down_ready=0, down_data and down_valid hold.
- Upstream protocol: up_valid/up_data must not be withdrawn before acceptance. Words are never dropped or duplicated; order is preserved.
- count:
  - +1 on an up transfer; -1 on a down transfer; unchanged when both or neither occur.
  - Inter-stage transfers do not change it.
  - Registered, updated on the same edge as the transfer.
  - Never exceeds N_STAGES*2**A_WIDTH; never underflows.
- almost_full: registered from the next-state count.
- flush:
  - While flush=1, up_ready and down_valid are forced to 0. No transfers occur.
  - On that edge all pointers, count and almost_full clear. The chain is empty the next cycle.
  - flush wins over any simultaneous handshake.
- Async reset mid-burst: everything clears immediately. Output is clean the first cycle after rst deasserts.

Optional Feature:
- Macro: FIFO_CHAIN_PEAK_EN.
- When defined:
  - Adds output port peak [CNT_W], a registered high-watermark of count.
  - Updated when next count > peak.
  - Cleared by rst and by flush.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan (defaults unless stated: capacity 8, CNT_W 4):
1. Reset release -> up_ready=1, down_valid=0, count=0, almost_full=0 on the first cycle.
2. down_ready=0; push 0x01..0x09 back-to-back:
   - 0x01..0x08 are accepted and count reaches 8.
   - almost_full=1 from the edge where count becomes 6.
   - up_ready=0 thereafter; 0x09 is held unaccepted.
   - Then down_ready=1 -> outputs 0x01..0x09 in order.
3. Empty chain, single push 0x2A at edge t, down_ready=1:
   - down_valid=1 with down_data=0x2A after edge t+1.
   - count goes 0->1->0.
   - With N_STAGES=4, appears after edge t+3.
4. up_valid=1 and down_ready=1 continuously, 20 incrementing words -> identical output order, no bubbles after the first word, count steady at 2.
5. 100 random words, random up_valid and 50% random down_ready:
   - Scoreboard shows no loss or duplication.
   - down_data stable during every stall.
   - count always equals scoreboard depth.
   - With FIFO_CHAIN_PEAK_EN, peak equals the max observed count.
6. Flush or async reset at count=5 while handshakes are active -> next cycle count=0, down_valid=0, up_ready=1, peak=0. A subsequent push 0x15 emerges intact.
